// File: rtl/median_window_gen_pkg.sv
// Shared constants for the 3x3 median window datapath: default pixel width,
// packed-window element indices and an element extraction helper.
package median_pkg;

    localparam int MEDIAN_DATA_W = 8;

    localparam int W_R0C0 = 0;
    localparam int W_R0C1 = 1;
    localparam int W_R0C2 = 2;
    localparam int W_R1C0 = 3;
    localparam int W_R1C1 = 4;
    localparam int W_R1C2 = 5;
    localparam int W_R2C0 = 6;
    localparam int W_R2C1 = 7;
    localparam int W_R2C2 = 8;

    localparam int WIN_CENTRE = 4;

    // Row 0 is the oldest line and column 0 the leftmost pixel.
    function automatic logic [MEDIAN_DATA_W-1:0] win_elem(
        input logic [9*MEDIAN_DATA_W-1:0] win,
        input int                         r,
        input int                         c
    );
        return win[(r*3+c)*MEDIAN_DATA_W +: MEDIAN_DATA_W];
    endfunction

endpackage

// File: rtl/median_window_gen_line_buf.sv
// One image line of pixel storage with a combinational read port and a write
// port at the same address; a read sees the value from before this cycle's write.
module median_line_buf
    import median_pkg::*;
#(
    parameter int DATA_W = MEDIAN_DATA_W,
    parameter int DEPTH  = 640
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Contents are deliberately not reset; window gating keeps stale lines hidden.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window_gen.sv
// Turns a raster pixel stream into a registered 3x3 neighbourhood for the median sorter.
// Optional MEDIAN_WIN_BORDER_EN also emits zero-padded border windows flagged by out_border.
module median_window_gen
    import median_pkg::*;
#(
    parameter int DATA_W     = MEDIAN_DATA_W,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    output logic [9*DATA_W-1:0]           out_win,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
    output logic                          out_border
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0]     x_cnt;
    logic [XW-1:0]     px;
    logic [XW-1:0]     x_next;
    logic [YW-1:0]     y_cnt;
    logic [YW-1:0]     py;
    logic [YW-1:0]     y_next;
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] win      [9];
    logic [DATA_W-1:0] win_next [9];
    logic [DATA_W-1:0] win_out  [9];
    logic              lb_wr;
    logic              emit;
    logic              border;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    assign px    = in_sof ? '0 : x_cnt;
    assign py    = in_sof ? '0 : y_cnt;
    assign lb_wr = in_valid && !rst;

    median_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH)
    ) lb0 (
        .clk     (clk),
        .wr_en   (lb_wr),
        .addr    (px),
        .wr_data (in_data),
        .rd_data (lb0_rd)
    );

    median_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_WIDTH)
    ) lb1 (
        .clk     (clk),
        .wr_en   (lb_wr),
        .addr    (px),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    always_comb begin
        x_next = px + XW'(1);
        y_next = py;
        if (px == X_LAST) begin
            x_next = '0;
            y_next = (py == Y_LAST) ? '0 : py + YW'(1);
        end
    end

    // Columns shift left; the freshly read column enters on the right.
    always_comb begin
        win_next[W_R0C0]     = win[W_R0C1];
        win_next[W_R0C1]     = win[W_R0C2];
        win_next[W_R0C2]     = lb1_rd;
        win_next[W_R1C0]     = win[W_R1C1];
        win_next[WIN_CENTRE] = win[W_R1C2];
        win_next[W_R1C2]     = lb0_rd;
        win_next[W_R2C0]     = win[W_R2C1];
        win_next[W_R2C1]     = win[W_R2C2];
        win_next[W_R2C2]     = in_data;
    end

`ifdef MEDIAN_WIN_BORDER_EN
    assign emit   = (px >= XW'(1)) && (py >= YW'(1));
    assign border = (px < XW'(2)) || (py < YW'(2));

    // Elements lying outside the frame are presented as zero.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_out[i] = win_next[i];
        end
        if (py < YW'(2)) begin
            win_out[W_R0C0] = '0;
            win_out[W_R0C1] = '0;
            win_out[W_R0C2] = '0;
        end
        if (px < XW'(2)) begin
            win_out[W_R0C0] = '0;
            win_out[W_R1C0] = '0;
            win_out[W_R2C0] = '0;
        end
    end
`else
    assign emit   = (px >= XW'(2)) && (py >= YW'(2));
    assign border = 1'b0;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_out[i] = win_next[i];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            out_valid  <= 1'b0;
            out_win    <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_border <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                x_cnt     <= x_next;
                y_cnt     <= y_next;
                out_valid <= emit;
                for (int i = 0; i < 9; i++) begin
                    win[i] <= win_next[i];
                end
                if (emit) begin
                    out_x      <= px - XW'(1);
                    out_y      <= py - YW'(1);
                    out_border <= border;
                    for (int i = 0; i < 9; i++) begin
                        out_win[i*DATA_W +: DATA_W] <= win_out[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on a 5x4 frame with pixel value y*16+x;
// the border-window checks apply when MEDIAN_WIN_BORDER_EN is defined.
`timescale 1ns/1ps
module tb_median_window_gen;
    import median_pkg::*;

    localparam int DATA_W     = 8;
    localparam int IMG_WIDTH  = 5;
    localparam int IMG_HEIGHT = 4;
    localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT;
`ifdef MEDIAN_WIN_BORDER_EN
    localparam bit BORDER_MODE = 1'b1;
    localparam int WINS_FRAME  = 12;
`else
    localparam bit BORDER_MODE = 1'b0;
    localparam int WINS_FRAME  = 6;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          in_valid;
    logic                          in_sof;
    logic [DATA_W-1:0]             in_data;
    logic                          out_valid;
    logic [9*DATA_W-1:0]           out_win;
    logic [$clog2(IMG_WIDTH)-1:0]  out_x;
    logic [$clog2(IMG_HEIGHT)-1:0] out_y;
    logic                          out_border;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    median_window_gen #(
        .DATA_W     (DATA_W),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_win    (out_win),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_border (out_border)
    );

    always #5 clk = ~clk;

    function automatic int pixval(input int x, input int y, input int fv, input int xr);
        if (x == 0 && y == 0 && fv >= 0) return fv;
        return ((y * 16 + x) ^ xr) & 255;
    endfunction

    function automatic bit exp_valid(input int x, input int y);
        if (BORDER_MODE) return (x >= 1) && (y >= 1);
        return (x >= 2) && (y >= 2);
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic stream_frame(input int gap, input bit sof, input int first, input int last,
                                input int fv, input int xr, output int wins);
        int x;
        int y;
        int xx;
        int yy;
        bit ev;
        logic [9*DATA_W-1:0] ew;
        wins = 0;
        for (int i = first; i < last; i++) begin
            x = i % IMG_WIDTH;
            y = i / IMG_WIDTH;
            drive(1'b1, sof && (i == first), 8'(pixval(x, y, fv, xr)));
            ev = exp_valid(x, y);
            assert_cnt++;
            if (out_valid !== ev) begin
                fail_cnt++;
                $display("[TB] FAIL valid at (%0d,%0d): got %b expected %b", x, y, out_valid, ev);
            end
            if (ev) begin
                wins++;
                ew = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        xx = x - 2 + c;
                        yy = y - 2 + r;
                        if (xx >= 0 && yy >= 0) ew[(r*3+c)*DATA_W +: DATA_W] = 8'(pixval(xx, yy, fv, xr));
                    end
                end
                assert_cnt += 4;
                if (out_win !== ew) begin
                    fail_cnt++;
                    $display("[TB] FAIL window at (%0d,%0d): got %h expected %h", x, y, out_win, ew);
                end
                if (out_x !== 3'(x - 1)) begin
                    fail_cnt++;
                    $display("[TB] FAIL out_x at (%0d,%0d): got %0d expected %0d", x, y, out_x, x - 1);
                end
                if (out_y !== 2'(y - 1)) begin
                    fail_cnt++;
                    $display("[TB] FAIL out_y at (%0d,%0d): got %0d expected %0d", x, y, out_y, y - 1);
                end
                if (out_border !== (BORDER_MODE && (x < 2 || y < 2))) begin
                    fail_cnt++;
                    $display("[TB] FAIL border at (%0d,%0d): got %b", x, y, out_border);
                end
            end
            if (gap != 0) begin
                drive(1'b0, 1'b0, 8'h5A);
                assert_cnt++;
                if (out_valid !== 1'b0) begin
                    fail_cnt++;
                    $display("[TB] FAIL idle valid after (%0d,%0d): got %b expected 0", x, y, out_valid);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        assert_cnt += 5;
        if (out_valid !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL %s out_valid: got %b expected 0", tag, out_valid);
        end
        if (out_win !== '0) begin
            fail_cnt++;
            $display("[TB] FAIL %s out_win: got %h expected 0", tag, out_win);
        end
        if (out_x !== '0) begin
            fail_cnt++;
            $display("[TB] FAIL %s out_x: got %0d expected 0", tag, out_x);
        end
        if (out_y !== '0) begin
            fail_cnt++;
            $display("[TB] FAIL %s out_y: got %0d expected 0", tag, out_y);
        end
        if (out_border !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL %s out_border: got %b expected 0", tag, out_border);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h77);
        drive(1'b1, 1'b1, 8'h66);
        check_cleared("reset");
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_frame();
        int w;
        logic [9*DATA_W-1:0] first_win;
        stream_frame(0, 1'b1, 0, 2 * IMG_WIDTH + 3, -1, 0, w);
        first_win = 72'h22_21_20_12_11_10_02_01_00;
        assert_cnt++;
        if (out_win !== first_win || out_x !== 3'd1 || out_y !== 2'd1) begin
            fail_cnt++;
            $display("[TB] FAIL first window: got %h x=%0d y=%0d expected %h x=1 y=1",
                     out_win, out_x, out_y, first_win);
        end
        begin
            int w2;
            stream_frame(0, 1'b0, 2 * IMG_WIDTH + 3, NPIX, -1, 0, w2);
            w += w2;
        end
        assert_cnt++;
        if (w !== WINS_FRAME) begin
            fail_cnt++;
            $display("[TB] FAIL frame count: got %0d expected %0d", w, WINS_FRAME);
        end
    endtask

    task automatic test_gaps();
        int w;
        stream_frame(1, 1'b1, 0, NPIX, -1, 0, w);
        assert_cnt++;
        if (w !== WINS_FRAME) begin
            fail_cnt++;
            $display("[TB] FAIL gapped count: got %0d expected %0d", w, WINS_FRAME);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        stream_frame(0, 1'b1, 0, 2 * IMG_WIDTH + 3, -1, 8'h80, w);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = 8'hB2;
        @(posedge clk);
        #1;
        check_cleared("mid reset");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        stream_frame(0, 1'b1, 0, 2 * IMG_WIDTH + 3, 8'hAA, 0, w);
        assert_cnt++;
        if (out_valid !== 1'b1 || win_elem(out_win, 0, 0) !== 8'hAA) begin
            fail_cnt++;
            $display("[TB] FAIL post-reset element 0: got valid=%b elem=%h expected valid=1 elem=aa",
                     out_valid, win_elem(out_win, 0, 0));
        end
        stream_frame(0, 1'b0, 2 * IMG_WIDTH + 3, NPIX, 8'hAA, 0, w);
    endtask

    task automatic test_back_to_back();
        int w1;
        int w2;
        stream_frame(0, 1'b1, 0, NPIX, -1, 0, w1);
        stream_frame(0, 1'b0, 0, NPIX, -1, 0, w2);
        assert_cnt += 2;
        if (w1 !== WINS_FRAME) begin
            fail_cnt++;
            $display("[TB] FAIL b2b frame1 count: got %0d expected %0d", w1, WINS_FRAME);
        end
        if (w2 !== WINS_FRAME) begin
            fail_cnt++;
            $display("[TB] FAIL b2b frame2 count: got %0d expected %0d", w2, WINS_FRAME);
        end
    endtask

    task automatic test_sof_mid();
        int w;
        stream_frame(0, 1'b1, 0, 3 * IMG_WIDTH + 2, -1, 8'h33, w);
        stream_frame(0, 1'b1, 0, NPIX, -1, 0, w);
        assert_cnt++;
        if (w !== WINS_FRAME) begin
            fail_cnt++;
            $display("[TB] FAIL sof restart count: got %0d expected %0d", w, WINS_FRAME);
        end
    endtask

`ifdef MEDIAN_WIN_BORDER_EN
    task automatic test_border();
        int w;
        stream_frame(0, 1'b1, 0, IMG_WIDTH + 2, -1, 0, w);
        assert_cnt++;
        if (out_border !== 1'b1 || out_x !== 3'd0 || out_y !== 2'd0 ||
            win_elem(out_win, 0, 0) !== 8'h00 || win_elem(out_win, 0, 1) !== 8'h00 ||
            win_elem(out_win, 0, 2) !== 8'h00 || win_elem(out_win, 1, 0) !== 8'h00 ||
            win_elem(out_win, 2, 0) !== 8'h00) begin
            fail_cnt++;
            $display("[TB] FAIL border centre (0,0): got border=%b x=%0d y=%0d win=%h",
                     out_border, out_x, out_y, out_win);
        end
        stream_frame(0, 1'b0, IMG_WIDTH + 2, 2 * IMG_WIDTH + 3, -1, 0, w);
        assert_cnt++;
        if (out_border !== 1'b0 || out_x !== 3'd1 || out_y !== 2'd1) begin
            fail_cnt++;
            $display("[TB] FAIL border centre (1,1): got border=%b x=%0d y=%0d expected 0 1 1",
                     out_border, out_x, out_y);
        end
        stream_frame(0, 1'b0, 2 * IMG_WIDTH + 3, NPIX, -1, 0, w);
    endtask
`endif

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        test_reset();
        test_frame();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_sof_mid();
`ifdef MEDIAN_WIN_BORDER_EN
        test_border();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/median_window_gen.md
Name: median_window_gen

Overview:
- Producer side of the 3x3 median datapath: turns a raster pixel stream into a registered 3x3 neighbourhood.
- Each window row is a pixel triple ready for the three-input sorter stage.
- Two internal line buffers hold the previous two image rows.
- Sits between the pixel source and the median sorting network.

Parameters:
DATA_W, 8, pixel width in bits
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data valid this cycle; no backpressure
in_sof  input  1  start of frame, qualified by in_valid
in_data  input  DATA_W  raster-order pixel
out_valid  output  1  out_win/out_x/out_y valid, one-cycle pulse
out_win  output  9*DATA_W  window, element r*3+c at [(r*3+c)*DATA_W +: DATA_W]; r0 = oldest row, c0 = leftmost column
out_x  output  $clog2(IMG_WIDTH)  window-centre column
out_y  output  $clog2(IMG_HEIGHT)  window-centre row
out_border  output  1  window incomplete (see Optional Feature)

Behaviour:
- Reset: when rst is high at a clock edge, the following are cleared:
  - out_valid=0, out_win=0, out_x=0, out_y=0, out_border=0.
  - Column counter x=0, row counter y=0, window registers=0.
  - Line-buffer contents are not cleared. Stale data never reaches a valid output.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
- Accept: every cycle with in_valid=1. With in_valid=0 all state holds and out_valid=0. Gaps of any length are allowed, inside a line or between lines.
- in_sof=1 with in_valid=1 forces the pixel to position (0,0), overriding the counters. in_sof without in_valid is ignored.
- Column formed per accepted pixel at (x,y): {lb1[x] (row y-2), lb0[x] (row y-1), in_data (row y)}.
- Line-buffer update, same cycle: lb1[x]<=lb0[x], lb0[x]<=in_data. Read-before-write at the same address.
- Window update: the three columns shift left by one; the new column enters at c2.
- Counters:
  - x increments per accepted pixel and wraps at IMG_WIDTH-1 to 0, which increments y.
  - y wraps at IMG_HEIGHT-1 to 0. The frame then ends without in_sof.
- Latency: exactly 1 clock. out_* is registered in the cycle after the accepting edge.
- Output centre: (x-1, y-1) of the pixel just accepted. out_x/out_y carry those values.
- Full window: x>=2 and y>=2. Without the feature, out_valid=1 only for full windows, so 638x478 outputs per frame at default parameters.
- Line wrap: the window's left columns at x=0,1 hold pixels from the previous line. These windows are never flagged full.
- in_sof arriving mid-frame restarts counters. Line-buffer content is then stale until two new lines are written, and the y>=2 gating guarantees it is not exposed.

Optional Feature:
- Macro: MEDIAN_WIN_BORDER_EN.
- Defined:
  - out_valid pulses for every accepted pixel with x>=1 and y>=1, i.e. every centre position of the frame except the last row/column.
  - out_border=1 when x<2 or y<2.
  - Window elements from missing rows/columns are forced to 0.
- Not defined: out_border is tied 0, and only full windows are emitted.

Decomposition:
- Package median_pkg:
  - DATA_W default.
  - Window index constants W_R0C0..W_R2C2 (0..8) and the WIN_CENTRE=4 localparam.
  - Function to extract element r,c from the packed window.
- Sub-module median_line_buf:
  - Depth IMG_WIDTH, width DATA_W.
  - Combinational read at addr, write on wr_en at the same addr, read-before-write.
  - Instantiated twice (lb0, lb1).

Test Plan:
- Reset then 5x4 frame (IMG_WIDTH=5, IMG_HEIGHT=4), pixel value = y*16+x:
  - First out_valid 1 cycle after pixel (2,2).
  - out_win = 00,01,02,10,11,12,20,21,22 (hex).
  - out_x=1, out_y=1.
  - 6 windows total.
- Same frame with in_valid toggled 1/0 each cycle: identical output sequence, each out_valid exactly 1 cycle after its accepting edge.
- rst asserted at pixel (3,2), then in_sof with value 0xAA:
  - out_valid=0 until new (2,2).
  - First window has 0xAA at element 0.
  - No pre-reset data appears.
- Back-to-back frames without in_sof: y wraps after (4,3), and frame 2 windows match frame 1 for identical data.
- in_sof at pixel (2,3) mid-frame: counters restart at (0,0), and the next out_valid occurs only after new (2,2).
- With MEDIAN_WIN_BORDER_EN, 5x4 frame:
  - 12 outputs.
  - Centre (0,0) window has out_border=1 and elements r0 and c0 = 0.
  - Centre (1,1) has out_border=0.
